// File: rtl/up_counter_sequencer.sv
// up_counter_sequencer: sequences a prescaled up-count from a configuration
// handshake and start/pause/stop commands. It supports one-shot and periodic modes.
// Optional build macro SEQ_WRAP_COUNT_EN adds the wrap_cnt output, a saturating
// count of periodic-mode terminal counts.
module up_counter_sequencer #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned PRE_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_limit,
   input  logic [PRE_W-1:0] cfg_prescale,
   input  logic             cfg_periodic,
   input  logic             start,
   input  logic             pause,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             step,
   output logic             tc,
   output logic             busy,
   output logic             done
`ifdef SEQ_WRAP_COUNT_EN
   ,
   output logic [7:0]       wrap_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [WIDTH-1:0] limit_q;
   logic [PRE_W-1:0] prescale_q;
   logic             periodic_q;
   logic             step_q, step_d;
   logic             tc_q, tc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             cfg_ready_q, cfg_ready_d;
   logic             cfg_hs;

   assign cfg_hs = cfg_valid & cfg_ready_q;

   // Next-state, datapath and status decode; stop beats pause beats step.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      step_d  = 1'b0;
      tc_d    = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            count_d = '0;
            presc_d = '0;
            state_d = stop ? S_IDLE : S_RUN;
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_IDLE;
               count_d = '0;
               presc_d = '0;
            end else if (pause) begin
               state_d = S_PAUSE;
            end else if (presc_q == prescale_q) begin
               presc_d = '0;
               step_d  = 1'b1;
               if (count_q == limit_q) begin
                  tc_d = 1'b1;
                  if (periodic_q) begin
                     count_d = '0;
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  count_d = WIDTH'(count_q + WIDTH'(1));
               end
            end else begin
               presc_d = PRE_W'(presc_q + PRE_W'(1));
            end
         end
         S_PAUSE: begin
            if (stop) begin
               state_d = S_IDLE;
               count_d = '0;
               presc_d = '0;
            end else if (!pause) begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
            count_d = '0;
            presc_d = '0;
         end
      endcase

      busy_d      = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_PAUSE);
      cfg_ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
      // done follows one cycle behind DONE entry and drops as soon as DONE is left
      done_d      = (state_q == S_DONE) && (state_d == S_DONE);
   end

   // State, datapath, latched configuration and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         presc_q     <= '0;
         limit_q     <= '1;
         prescale_q  <= '0;
         periodic_q  <= 1'b0;
         step_q      <= 1'b0;
         tc_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_ready_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         presc_q     <= presc_d;
         step_q      <= step_d;
         tc_q        <= tc_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         cfg_ready_q <= cfg_ready_d;
         if (cfg_hs) begin
            limit_q    <= cfg_limit;
            prescale_q <= cfg_prescale;
            periodic_q <= cfg_periodic;
         end
      end
   end

   assign count     = count_q;
   assign step      = step_q;
   assign tc        = tc_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign cfg_ready = cfg_ready_q;

`ifdef SEQ_WRAP_COUNT_EN
   localparam int unsigned WRAP_W = 8;

   logic [WRAP_W-1:0] wrap_q, wrap_d;

   // Saturating count of periodic terminal counts, cleared on each arm.
   always_comb begin
      wrap_d = wrap_q;
      if ((state_d == S_ARM) && (state_q != S_ARM)) begin
         wrap_d = '0;
      end else if (tc_d && periodic_q && (wrap_q != '1)) begin
         wrap_d = WRAP_W'(wrap_q + WRAP_W'(1));
      end
   end

   // Wrap counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrap_q <= '0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   assign wrap_cnt = wrap_q;
`else
   // Wrap counter not present in this build.
`endif

endmodule

// File: tb/tb_up_counter_sequencer.sv
// Bench for up_counter_sequencer: randomized and directed runs checked against a
// closed-form model of count/step/tc/busy/done as a function of cycles spent in RUN.
module tb_up_counter_sequencer;

   localparam int unsigned WIDTH = 4;
   localparam int unsigned PRE_W = 4;

   logic             clk;
   logic             rst;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [WIDTH-1:0] cfg_limit;
   logic [PRE_W-1:0] cfg_prescale;
   logic             cfg_periodic;
   logic             start;
   logic             pause;
   logic             stop;
   logic [WIDTH-1:0] count;
   logic             step;
   logic             tc;
   logic             busy;
   logic             done;
`ifdef SEQ_WRAP_COUNT_EN
   logic [7:0]       wrap_cnt;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] count;
      logic             step;
      logic             tc;
      logic             busy;
      logic             done;
      logic [7:0]       wrap;
   } obs_t;

   int n_checks = 0;
   int n_fail   = 0;

   up_counter_sequencer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_limit    (cfg_limit),
      .cfg_prescale (cfg_prescale),
      .cfg_periodic (cfg_periodic),
      .start        (start),
      .pause        (pause),
      .stop         (stop),
      .count        (count),
      .step         (step),
      .tc           (tc),
      .busy         (busy),
      .done         (done)
`ifdef SEQ_WRAP_COUNT_EN
      ,
      .wrap_cnt     (wrap_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs n cycles after entering RUN (pause cycles excluded).
   function automatic obs_t model(input int n, input int lim, input int pre, input bit per);
      obs_t e;
      int   s;
      int   ph;
      int   t;
      int   w;
      e  = '0;
      s  = n / (pre + 1);
      ph = n % (pre + 1);
      if (!per) begin
         t       = (lim + 1) * (pre + 1);
         e.count = WIDTH'((s < lim) ? s : lim);
         e.step  = (n > 0) && (ph == 0) && (n <= t);
         e.tc    = (n == t);
         e.busy  = (n < t);
         e.done  = (n >= t + 1);
      end else begin
         e.count = WIDTH'(s % (lim + 1));
         e.step  = (n > 0) && (ph == 0);
         e.tc    = e.step && ((s % (lim + 1)) == 0);
         e.busy  = 1'b1;
         e.done  = 1'b0;
`ifdef SEQ_WRAP_COUNT_EN
         w      = s / (lim + 1);
         e.wrap = 8'((w > 255) ? 255 : w);
`else
         w      = 0;
         e.wrap = 8'(w);
`endif
      end
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.count = count;
      o.step  = step;
      o.tc    = tc;
      o.busy  = busy;
      o.done  = done;
`ifdef SEQ_WRAP_COUNT_EN
      o.wrap  = wrap_cnt;
`else
      o.wrap  = 8'd0;
`endif
      return o;
   endfunction

   function automatic string fmt(input obs_t o);
      return $sformatf("cnt=%0d step=%b tc=%b busy=%b done=%b wrap=%0d",
                       o.count, o.step, o.tc, o.busy, o.done, o.wrap);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer start (optionally with config) and advance to the first RUN cycle.
   task automatic start_run(input int lim, input int pre, input bit per, input bit use_cfg);
      cfg_valid    = use_cfg;
      cfg_limit    = WIDTH'(lim);
      cfg_prescale = PRE_W'(pre);
      cfg_periodic = per;
      start        = 1'b1;
      tick();
      cfg_valid = 1'b0;
      start     = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      n_checks++; if (count !== '0)       begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
      n_checks++; if ({step, tc} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got=%b%b exp=00", step, tc); end
   endtask

   task automatic test_oneshot();
      obs_t got, exp;
      start_run(5, 0, 1'b0, 1'b1);
      for (int n = 0; n <= 9; n++) begin
         got = sample();
         exp = model(n, 5, 0, 1'b0);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL oneshot n=%0d got %s exp %s", n, fmt(got), fmt(exp));
         end
         tick();
      end
   endtask

   task automatic test_periodic();
      obs_t got, exp;
      start_run(3, 2, 1'b1, 1'b1);
      for (int n = 0; n <= 30; n++) begin
         got = sample();
         exp = model(n, 3, 2, 1'b1);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL periodic n=%0d got %s exp %s", n, fmt(got), fmt(exp));
         end
         // start while busy must be ignored
         start = (n >= 5) && (n < 9);
         tick();
      end
      start = 1'b0;
      stop  = 1'b1;
      tick();
      stop  = 1'b0;
      n_checks++;
      if ({count, busy, cfg_ready} !== {WIDTH'(0), 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL periodic_stop got cnt=%0d busy=%b rdy=%b exp cnt=0 busy=0 rdy=1", count, busy, cfg_ready);
      end
   endtask

   task automatic test_pause();
      obs_t got, exp;
      start_run(15, 0, 1'b0, 1'b1);
      for (int n = 0; n <= 7; n++) begin
         got = sample();
         exp = model(n, 15, 0, 1'b0);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL pause_pre n=%0d got %s exp %s", n, fmt(got), fmt(exp));
         end
         if (n < 7) tick();
      end
      exp      = model(7, 15, 0, 1'b0);
      exp.step = 1'b0;
      exp.tc   = 1'b0;
      pause    = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) pause = 1'b0;
         tick();
         got = sample();
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL pause_hold k=%0d got %s exp %s", k, fmt(got), fmt(exp));
         end
      end
      for (int n = 8; n <= 18; n++) begin
         tick();
         got = sample();
         exp = model(n, 15, 0, 1'b0);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL pause_post n=%0d got %s exp %s", n, fmt(got), fmt(exp));
         end
      end
   endtask

   task automatic test_stop();
      obs_t got, exp;
      start_run(6, 0, 1'b0, 1'b1);
      for (int n = 0; n <= 4; n++) begin
         got = sample();
         exp = model(n, 6, 0, 1'b0);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL stop_run n=%0d got %s exp %s", n, fmt(got), fmt(exp));
         end
         if (n == 2) begin
            cfg_valid    = 1'b1;
            cfg_limit    = WIDTH'(2);
            cfg_prescale = PRE_W'(3);
            cfg_periodic = 1'b1;
         end
         if (n == 3) begin
            n_checks++;
            if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL stop_cfg_ready_run got=%b exp=0", cfg_ready); end
         end
         if (n < 4) tick();
      end
      cfg_valid = 1'b0;
      stop      = 1'b1;
      tick();
      stop      = 1'b0;
      n_checks++;
      if ({count, busy, cfg_ready, done, step} !== {WIDTH'(0), 1'b0, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL stop_idle got cnt=%0d busy=%b rdy=%b done=%b step=%b exp cnt=0 busy=0 rdy=1 done=0 step=0",
                  count, busy, cfg_ready, done, step);
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      n_checks++;
      if ({busy, cfg_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL stop_in_idle got busy=%b rdy=%b exp busy=0 rdy=1", busy, cfg_ready);
      end
      // the config offered during RUN must not have been taken
      start_run(6, 0, 1'b0, 1'b0);
      for (int n = 0; n <= 9; n++) begin
         got = sample();
         exp = model(n, 6, 0, 1'b0);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL stop_rerun n=%0d got %s exp %s", n, fmt(got), fmt(exp));
         end
         tick();
      end
   endtask

   task automatic test_same_cycle_cfg_start();
      obs_t got, exp;
      start_run(0, 0, 1'b0, 1'b1);
      for (int n = 0; n <= 3; n++) begin
         got = sample();
         exp = model(n, 0, 0, 1'b0);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL limit0 n=%0d got %s exp %s", n, fmt(got), fmt(exp));
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      obs_t got, exp;
      start_run(9, 1, 1'b1, 1'b1);
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      got = sample();
      n_checks++;
      if ((got !== obs_t'('0)) || (cfg_ready !== 1'b1)) begin
         n_fail++;
         $display("FAIL reset_mid got %s rdy=%b exp %s rdy=1", fmt(got), cfg_ready, fmt(obs_t'('0)));
      end
      // reset config is limit 15, prescale 0, one-shot
      start_run(3, 2, 1'b1, 1'b0);
      for (int n = 0; n <= 18; n++) begin
         got = sample();
         exp = model(n, 15, 0, 1'b0);
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_cfg n=%0d got %s exp %s", n, fmt(got), fmt(exp));
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      obs_t got, exp;
      int   lim, pre, ncyc;
      bit   per;
      for (int it = 0; it < 8; it++) begin
         lim  = int'($urandom_range(0, 15));
         pre  = int'($urandom_range(0, 3));
         per  = 1'($urandom_range(0, 1));
         ncyc = per ? 2 * (lim + 1) * (pre + 1) + 2 : (lim + 1) * (pre + 1) + 3;
         start_run(lim, pre, per, 1'b1);
         for (int n = 0; n <= ncyc; n++) begin
            got = sample();
            exp = model(n, lim, pre, per);
            n_checks++;
            if (got !== exp) begin
               n_fail++;
               $display("FAIL b2b it=%0d L=%0d P=%0d per=%0d n=%0d got %s exp %s",
                        it, lim, pre, per, n, fmt(got), fmt(exp));
            end
            tick();
         end
         if (per) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            n_checks++;
            if ({count, busy} !== {WIDTH'(0), 1'b0}) begin
               n_fail++;
               $display("FAIL b2b_stop it=%0d got cnt=%0d busy=%b exp cnt=0 busy=0", it, count, busy);
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      cfg_valid    = 1'b0;
      cfg_limit    = '0;
      cfg_prescale = '0;
      cfg_periodic = 1'b0;
      start        = 1'b0;
      pause        = 1'b0;
      stop         = 1'b0;
      test_reset();
      test_oneshot();
      test_periodic();
      test_pause();
      test_stop();
      test_same_cycle_cfg_start();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/up_counter_sequencer.md
Name: up_counter_sequencer

Overview:
Programmable controller that sequences the 4-bit up-count datapath: takes a configuration handshake, then start/pause/stop commands, and steps the count at a prescaled rate up to a programmed limit. Supports one-shot and periodic modes. Sits between the control/register logic and the counter, and reports busy, terminal-count and done status back to software-facing logic.

Parameters:
WIDTH, 4, count and limit width
PRE_W, 4, prescaler width; a step occurs every (prescale+1) cycles

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration accepted when cfg_valid & cfg_ready
cfg_limit  input  WIDTH  terminal count value
cfg_prescale  input  PRE_W  cycles-per-step minus 1
cfg_periodic  input  1  0 = one-shot, 1 = periodic
start  input  1  start request (level sampled each cycle)
pause  input  1  freeze while high
stop  input  1  abort to IDLE
count  output  WIDTH  current count
step  output  1  1-cycle pulse on each count update
tc  output  1  1-cycle pulse when count reaches limit on a step
busy  output  1  high in ARM, RUN, PAUSE
done  output  1  level, high in DONE

Behaviour:
- Reset: state = IDLE; count = 0, prescaler = 0, step = tc = done = busy = 0, cfg_ready = 1; latched config = limit 4'hF, prescale 0, periodic 0.
- cfg_ready = 1 only in IDLE and DONE. A handshake latches limit, prescale and periodic on that edge.
- IDLE: start -> ARM. If cfg handshake and start occur in the same cycle, the new config is used.
- DONE: done = 1 and count holds. start -> ARM. cfg is accepted.
- ARM (1 cycle): count <= 0, prescaler <= 0, then -> RUN. busy rises the cycle after start is sampled.
- RUN: prescaler increments each cycle. When prescaler == prescale, the prescaler resets to 0 and a step occurs.
  - On a step with count == limit:
    - tc = 1 and step = 1.
    - One-shot: count holds at limit, then -> DONE.
    - Periodic: count <= 0 and the state stays RUN.
  - On a step with count != limit: count <= count + 1, mod 2^WIDTH.
  - limit == 0: every step is a terminal step.
- First step latency: prescale+1 cycles after entering RUN.
  - One-shot with limit L, prescale P: done asserts (L+1)·(P+1)+1 cycles after entering RUN.
- step and tc are registered pulses, asserted in the cycle after the update edge and aligned with the new count.
- PAUSE: entered from RUN when pause = 1. count and prescaler are frozen and no step occurs. Returns to RUN when pause = 0, and the prescaler resumes from its frozen value.
- stop in ARM, RUN or PAUSE -> IDLE next edge, with count <= 0 and prescaler <= 0. stop in IDLE or DONE has no effect.
- Priority when inputs coincide: rst > stop > pause > step.
  - A step coinciding with pause is suppressed.
  - start is ignored while busy.
- start held high in DONE re-arms immediately: DONE -> ARM.
- Reset mid-operation returns everything to the reset values on the next edge.

Optional Feature:
SEQ_WRAP_COUNT_EN
- Defined: adds output wrap_cnt[7:0], which increments on each periodic-mode tc and saturates at 8'hFF. It is cleared by rst, and on entry to ARM.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- rst held 2 cycles, then released -> count = 0, busy = 0, done = 0, cfg_ready = 1.
- cfg limit = 5, prescale = 0, one-shot, then start -> count 0,1,...,5 on consecutive cycles. tc pulses once at count = 5, done = 1 the next cycle, and count holds at 5.
- limit = 3, prescale = 2, periodic -> step every 3 cycles, count 0,1,2,3,0,1... with tc on each 3. With SEQ_WRAP_COUNT_EN, wrap_cnt = 2 after two wraps.
- limit = 15, prescale = 0, one-shot. Pause held 4 cycles at count = 7 -> count stays 7 with no step, then resumes to 8.
- stop while RUN at count = 4 -> IDLE next cycle, count = 0, busy = 0. cfg_valid with cfg_ready = 0 in RUN is not accepted.
- cfg_valid and start in the same IDLE cycle with limit = 0, one-shot -> tc on the first step and done.
